// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and timing constants for the SPI monarch
package spi_pkg;
    typedef enum logic {IDLE, TRANS} state_t;
    localparam int         SPI_WIDTH     = 16;
    localparam logic [3:0] SCLK_DIV_INIT = 4'b1011;
    localparam logic [3:0] SMPL_CNT      = 4'b0111;
    localparam logic [3:0] SHFT_CNT      = 4'b1111;
endpackage

// File: rtl/spi_mnrch.sv
// spi_mnrch: single-word 16-bit full-duplex SPI monarch, SCLK = clk/16
module spi_mnrch
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrt,
    input  logic [SPI_WIDTH-1:0] wt_data,
    input  logic                 MISO,
    output logic                 SS_n,
    output logic                 SCLK,
    output logic                 MOSI,
    output logic                 done,
    output logic [SPI_WIDTH-1:0] rd_data
);
    state_t state, nxt;
    logic [3:0] div, cnt;
    logic [SPI_WIDTH-1:0] shft_reg;
    logic smpl, porch, ld, shift, fin;

    assign SCLK    = div[3];
    assign MOSI    = shft_reg[SPI_WIDTH-1];
    assign rd_data = shft_reg;

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;

    // next state and datapath strobes; the first SCLK fall (porch) never shifts
    always_comb begin
        nxt = state;
        ld = 1'b0;
        shift = 1'b0;
        fin = 1'b0;
        if (state == IDLE) begin
            ld = wrt;
            nxt = wrt ? TRANS : IDLE;
        end else if (div == SHFT_CNT && !porch) begin
            shift = 1'b1;
            fin = cnt == 4'(SPI_WIDTH - 1);
            nxt = fin ? IDLE : TRANS;
        end
    end

    // SCLK divider: parked high in IDLE and reloaded on the last shift
    always_ff @(posedge clk or posedge rst)
        if (rst) div <= SCLK_DIV_INIT;
        else if (state == IDLE || fin) div <= SCLK_DIV_INIT;
        else div <= div + 4'd1;

    // front-porch flag: cleared by the first SCLK fall after load
    always_ff @(posedge clk or posedge rst)
        if (rst) porch <= 1'b0;
        else if (ld) porch <= 1'b1;
        else if (div == SHFT_CNT) porch <= 1'b0;

    // MISO captured just before SCLK rises
    always_ff @(posedge clk or posedge rst)
        if (rst) smpl <= 1'b0;
        else if (state == TRANS && div == SMPL_CNT) smpl <= MISO;

    // shift register and bit counter
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            shft_reg <= '0;
            cnt <= '0;
        end else if (ld) begin
            shft_reg <= wt_data;
            cnt <= '0;
        end else if (shift) begin
            shft_reg <= {shft_reg[SPI_WIDTH-2:0], smpl};
            cnt <= cnt + 4'd1;
        end

    // select and completion flags
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            SS_n <= 1'b1;
            done <= 1'b0;
        end else if (ld) begin
            SS_n <= 1'b0;
            done <= 1'b0;
        end else if (fin) begin
            SS_n <= 1'b1;
            done <= 1'b1;
        end
endmodule

// File: tb/tb_spi_mnrch.sv
// tb_spi_mnrch: directed bench for spi_mnrch with loopback and a simple inertial serf model
module tb_spi_mnrch;
    logic clk = 1'b0;
    logic rst, wrt, loop;
    logic [15:0] wt_data;
    logic MISO, SS_n, SCLK, MOSI, done;
    logic [15:0] rd_data;
    int total = 0;
    int bad = 0;

    spi_mnrch dut (
        .clk(clk), .rst(rst), .wrt(wrt), .wt_data(wt_data), .MISO(MISO),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .done(done), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // serf model: captures MOSI on SCLK rise, answers a read in the second byte
    logic [4:0] r = '0;
    logic [15:0] rx = '0;
    logic [6:0] addr = '0;
    logic int_o = 1'b0;
    logic [7:0] sbyte;
    logic serf_miso;

    function automatic logic [7:0] reg_val(input logic [6:0] a);
        case (a)
            7'h0F: reg_val = 8'h6A;
            7'h22: reg_val = 8'h3C;
            7'h23: reg_val = 8'h81;
            7'h24: reg_val = 8'hE7;
            7'h25: reg_val = 8'h05;
            7'h26: reg_val = 8'h9A;
            7'h27: reg_val = 8'h42;
            7'h28: reg_val = 8'hD3;
            7'h29: reg_val = 8'h18;
            7'h2A: reg_val = 8'h7E;
            7'h2B: reg_val = 8'hC6;
            default: reg_val = 8'h00;
        endcase
    endfunction

    always @(posedge SCLK or posedge SS_n)
        if (SS_n) begin
            if (r == 5'd16 && !rx[15] && rx[14:8] == 7'h0D && rx[7:0] == 8'h02) int_o <= 1'b1;
            r <= '0;
        end else begin
            rx <= {rx[14:0], MOSI};
            if (r == 5'd7) addr <= {rx[5:0], MOSI};
            r <= r + 5'd1;
        end

    assign sbyte = reg_val(addr);
    assign serf_miso = (r >= 5'd8 && r < 5'd16) ? sbyte[3'(5'd15 - r)] : 1'b0;
    assign MISO = loop ? MOSI : serf_miso;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] d, input int ign_at, output int done_at, output int ss_low,
                       output int rises, output int bad_gap, output int first_rise, output logic d0);
        int last;
        logic pclk;
        wrt = 1'b1;
        wt_data = d;
        tick;
        wrt = 1'b0;
        d0 = done;
        ss_low = SS_n ? 0 : 1;
        rises = 0;
        bad_gap = 0;
        first_rise = -1;
        done_at = -1;
        last = 0;
        pclk = SCLK;
        for (int n = 1; n <= 400 && done_at < 0; n++) begin
            if (n == ign_at) begin
                wrt = 1'b1;
                wt_data = 16'hFFFF;
            end
            tick;
            wrt = 1'b0;
            if (!SS_n) ss_low++;
            if (SCLK && !pclk) begin
                rises++;
                if (first_rise < 0) first_rise = n;
                else if (n - last != 16) bad_gap++;
                last = n;
            end
            pclk = SCLK;
            if (done) done_at = n;
        end
    endtask

    task automatic test_reset;
        total += 5;
        if (SS_n !== 1'b1) begin bad++; $display("FAIL reset_ss_n got=%b exp=1", SS_n); end
        if (SCLK !== 1'b1) begin bad++; $display("FAIL reset_sclk got=%b exp=1", SCLK); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        if (rd_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        if (MOSI !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", MOSI); end
        rst = 1'b0;
        repeat (3) tick;
        total += 2;
        if (SS_n !== 1'b1) begin bad++; $display("FAIL idle_ss_n got=%b exp=1", SS_n); end
        if (SCLK !== 1'b1) begin bad++; $display("FAIL idle_sclk got=%b exp=1", SCLK); end
    endtask

    task automatic test_loopback;
        int da, sl, ri, bg, fr;
        logic d0;
        loop = 1'b1;
        run(16'hA5C3, 0, da, sl, ri, bg, fr, d0);
        total += 8;
        if (da != 261) begin bad++; $display("FAIL lb_done_at got=%0d exp=261", da); end
        if (sl != 261) begin bad++; $display("FAIL lb_ss_low got=%0d exp=261", sl); end
        if (ri != 16) begin bad++; $display("FAIL lb_rises got=%0d exp=16", ri); end
        if (bg != 0) begin bad++; $display("FAIL lb_gaps got=%0d exp=0", bg); end
        if (fr != 13) begin bad++; $display("FAIL lb_first_rise got=%0d exp=13", fr); end
        if (rd_data !== 16'hA5C3) begin bad++; $display("FAIL lb_rd_data got=%h exp=a5c3", rd_data); end
        if (SCLK !== 1'b1 || SS_n !== 1'b1) begin bad++; $display("FAIL lb_end_idle got=%b%b exp=11", SCLK, SS_n); end
        if (d0 !== 1'b0) begin bad++; $display("FAIL lb_done_clear got=%b exp=0", d0); end
        repeat (5) tick;
        total += 1;
        if (done !== 1'b1 || rd_data !== 16'hA5C3) begin bad++; $display("FAIL lb_hold got=%b/%h exp=1/a5c3", done, rd_data); end
    endtask

    task automatic test_who_am_i;
        int da, sl, ri, bg, fr;
        logic d0;
        loop = 1'b0;
        run(16'h8F00, 0, da, sl, ri, bg, fr, d0);
        total += 3;
        if (da < 1 || da > 300) begin bad++; $display("FAIL who_done_at got=%0d exp=1..300", da); end
        if (rx !== 16'h8F00) begin bad++; $display("FAIL who_mosi_stream got=%h exp=8f00", rx); end
        if (rd_data !== 16'h006A) begin bad++; $display("FAIL who_rd_data got=%h exp=006a", rd_data); end
    endtask

    task automatic test_serf_regs;
        int da, sl, ri, bg, fr;
        logic d0;
        logic [7:0] exp_b [10] = '{8'h3C, 8'h81, 8'hE7, 8'h05, 8'h9A, 8'h42, 8'hD3, 8'h18, 8'h7E, 8'hC6};
        loop = 1'b0;
        run(16'h0D02, 0, da, sl, ri, bg, fr, d0);
        tick;
        total += 2;
        if (done !== 1'b1) begin bad++; $display("FAIL wr_done got=%b exp=1", done); end
        if (int_o !== 1'b1) begin bad++; $display("FAIL wr_int got=%b exp=1", int_o); end
        for (int i = 0; i < 10; i++) begin
            run({8'hA2 + 8'(i), 8'h00}, 0, da, sl, ri, bg, fr, d0);
            total += 1;
            if (da != 261 || rd_data[7:0] !== exp_b[i])
                begin bad++; $display("FAIL rd_reg%0d got=%h@%0d exp=%h@261", i, rd_data[7:0], da, exp_b[i]); end
        end
    endtask

    task automatic test_ignored;
        int da, sl, ri, bg, fr;
        logic d0;
        loop = 1'b1;
        run(16'h3C5A, 50, da, sl, ri, bg, fr, d0);
        total += 3;
        if (da != 261) begin bad++; $display("FAIL ign_done_at got=%0d exp=261", da); end
        if (rd_data !== 16'h3C5A) begin bad++; $display("FAIL ign_rd_data got=%h exp=3c5a", rd_data); end
        if (ri != 16) begin bad++; $display("FAIL ign_rises got=%0d exp=16", ri); end
    endtask

    task automatic test_reset_mid;
        int da, sl, ri, bg, fr;
        logic d0;
        loop = 1'b1;
        wrt = 1'b1;
        wt_data = 16'h5555;
        tick;
        wrt = 1'b0;
        repeat (99) tick;
        total += 1;
        if (SS_n !== 1'b0) begin bad++; $display("FAIL mid_active got=%b exp=0", SS_n); end
        rst = 1'b1;
        #1;
        total += 4;
        if (SS_n !== 1'b1) begin bad++; $display("FAIL mid_ss_n got=%b exp=1", SS_n); end
        if (SCLK !== 1'b1) begin bad++; $display("FAIL mid_sclk got=%b exp=1", SCLK); end
        if (done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", done); end
        if (rd_data !== 16'h0000) begin bad++; $display("FAIL mid_rd_data got=%h exp=0000", rd_data); end
        #2 rst = 1'b0;
        tick;
        run(16'h1234, 0, da, sl, ri, bg, fr, d0);
        total += 2;
        if (da != 261) begin bad++; $display("FAIL mid_after_done got=%0d exp=261", da); end
        if (rd_data !== 16'h1234) begin bad++; $display("FAIL mid_after_data got=%h exp=1234", rd_data); end
    endtask

    task automatic test_back_to_back;
        int da, sl, ri, bg, fr;
        logic d0;
        loop = 1'b1;
        run(16'h1111, 0, da, sl, ri, bg, fr, d0);
        total += 1;
        if (da != 261 || rd_data !== 16'h1111) begin bad++; $display("FAIL b2b_first got=%h@%0d exp=1111@261", rd_data, da); end
        run(16'hEEEE, 0, da, sl, ri, bg, fr, d0);
        total += 4;
        if (d0 !== 1'b0) begin bad++; $display("FAIL b2b_done_drop got=%b exp=0", d0); end
        if (da != 261) begin bad++; $display("FAIL b2b_done_at got=%0d exp=261", da); end
        if (sl != 261) begin bad++; $display("FAIL b2b_ss_low got=%0d exp=261", sl); end
        if (rd_data !== 16'hEEEE) begin bad++; $display("FAIL b2b_rd_data got=%h exp=eeee", rd_data); end
    endtask

    initial begin
        rst = 1'b1;
        wrt = 1'b0;
        wt_data = 16'h0000;
        loop = 1'b1;
        repeat (2) tick;
        test_reset;
        test_loopback;
        test_who_am_i;
        test_serf_regs;
        test_ignored;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
